// File: rtl/postmortem_capture_ctrl.sv
// Postmortem capture sequencer: shared write strobe, circular write
// address, fault-triggered freeze, trigger address and history status.
// Optional macro POSTMORTEM_SW_TRIG_EN adds i_sw_trig as a trigger source.
// Ports:
//   i_clk, i_rst (async, active high)
//   i_arm, i_sample_tick, i_fault, i_sw_trig, i_post_cnt
//   o_ram_we, o_w_ram_addr, o_trig_addr, o_state, o_hist_full, o_done
module postmortem_capture_ctrl #(
  parameter int RAM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_arm,
  input  logic                  i_sample_tick,
  input  logic                  i_fault,
  input  logic                  i_sw_trig,
  input  logic [ADDR_WIDTH-1:0] i_post_cnt,
  output logic                  o_ram_we,
  output logic [31:0]           o_w_ram_addr,
  output logic [31:0]           o_trig_addr,
  output logic [1:0]            o_state,
  output logic                  o_hist_full,
  output logic                  o_done
);

  localparam int FW = ADDR_WIDTH + 1;
  localparam logic [FW-1:0] DEPTH_L = FW'(RAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic                  fault_q;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] trig_q, trig_d;
  logic                  hist_q, hist_d;

  logic          armed;
  logic          writing;
  logic          fault_rise;
  logic          trig;
  logic          rearm;
  logic [FW-1:0] fill_now;

  assign armed      = (state_q == S_ARMED);
  assign writing    = i_sample_tick &&
                      (state_q == S_ARMED || state_q == S_POST);
  assign fault_rise = i_fault & ~fault_q;
  assign rearm      = i_arm &&
                      (state_q == S_IDLE || state_q == S_DONE);

`ifdef POSTMORTEM_SW_TRIG_EN
  assign trig = armed & (fault_rise | i_sw_trig);
`else
  logic unused_sw_trig;
  assign unused_sw_trig = i_sw_trig;
  assign trig = armed & fault_rise;
`endif

  // Fill count through the trigger sample: a same-cycle tick is the
  // trigger sample itself, so it is counted as history.
  assign fill_now = (i_sample_tick && fill_q != DEPTH_L)
                  ? fill_q + FW'(1) : fill_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig) begin
          state_d = (i_post_cnt == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (i_sample_tick && post_q <= ADDR_WIDTH'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    post_d   = post_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    trig_d   = trig_q;
    hist_d   = hist_q;

    if (writing) begin
      we_d     = 1'b1;
      waddr_d  = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (armed) fill_d = fill_now;
      if (state_q == S_POST) post_d = post_q - ADDR_WIDTH'(1);
    end

    if (trig) begin
      post_d = i_post_cnt;
      hist_d = (fill_now >= (DEPTH_L - {1'b0, i_post_cnt}));
      trig_d = i_sample_tick ? wr_ptr_q
                             : wr_ptr_q - ADDR_WIDTH'(1);
    end

    if (rearm) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      waddr_d  = '0;
      trig_d   = '0;
      hist_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      post_q   <= '0;
      fault_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      trig_q   <= '0;
      hist_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      post_q   <= post_d;
      fault_q  <= i_fault;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      trig_q   <= trig_d;
      hist_q   <= hist_d;
    end
  end

  always_comb begin
    o_ram_we     = we_q;
    o_w_ram_addr = {{(32-ADDR_WIDTH){1'b0}}, waddr_q};
    o_trig_addr  = {{(32-ADDR_WIDTH){1'b0}}, trig_q};
    o_state      = state_q;
    o_hist_full  = hist_q;
    o_done       = (state_q == S_DONE);
  end

endmodule

// File: doc/postmortem_capture_ctrl.md
# postmortem_capture_ctrl

Sequencer for the postmortem capture RAMs. It generates the shared write strobe and circular write address for all ten capture channels (current, voltage, DC-link current/voltage, IGBT, input/output IDT, RMS R/S/T). It freezes capture a programmable number of samples after a fault, and reports the trigger address and status. It sits between the sampling/fault logic and the capture RAMs. `o_w_ram_addr` feeds the write-address readback register of the AXI4-Lite postmortem register block.

## Interface
Parameters:
- `RAM_DEPTH`, 1024 — entries per capture RAM; must be a power of 2, minimum 4.
- `ADDR_WIDTH`, `$clog2(RAM_DEPTH)` — internal pointer width.

Ports:
- `i_clk` input 1 — the single clock.
- `i_rst` input 1 — asynchronous, active-high reset.
- `i_arm` input 1 — single-cycle pulse; starts a new capture.
- `i_sample_tick` input 1 — single-cycle pulse; one sample is available on all channels.
- `i_fault` input 1 — synchronous fault level; its rising edge is the trigger.
- `i_sw_trig` input 1 — software trigger pulse; used only with `POSTMORTEM_SW_TRIG_EN`.
- `i_post_cnt` input ADDR_WIDTH — number of post-trigger samples; sampled at the trigger.
- `o_ram_we` output 1 — write strobe common to all capture RAMs.
- `o_w_ram_addr` output 32 — write address, zero-extended from ADDR_WIDTH bits.
- `o_trig_addr` output 32 — address of the trigger sample, zero-extended.
- `o_state` output 2 — 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `o_hist_full` output 1 — at least RAM_DEPTH−post_cnt samples were written before the trigger.
- `o_done` output 1 — level; high while in DONE.

## Operation
- Reset: state IDLE; `wr_ptr`, fill counter, post counter and the fault-edge register = 0. All outputs = 0.
- IDLE:
  - `i_arm` → ARMED; `wr_ptr` := 0; fill counter := 0.
  - `i_sample_tick` is ignored.
- ARMED:
  - Each tick writes one sample at `wr_ptr`; `wr_ptr` += 1 mod RAM_DEPTH.
  - The fill counter increments and saturates at RAM_DEPTH.
- Trigger (ARMED only): `i_fault` high this cycle and low the previous cycle.
  - On trigger: `post_cnt_r` := `i_post_cnt`. `o_hist_full` := (fill ≥ RAM_DEPTH − `i_post_cnt`). `o_trig_addr` := the trigger sample address.
  - Trigger sample address: `wr_ptr` if a tick occurs in the same cycle, else `wr_ptr`−1 mod RAM_DEPTH.
  - Next state is POST, or DONE if the effective post count is 0.
- POST:
  - Each tick writes one sample and decrements the post counter.
  - The write that brings the counter to 0 → DONE.
- DONE:
  - No writes; `wr_ptr` is frozen; `o_done` = 1.
  - `i_arm` → ARMED, re-initialised as from IDLE; `o_hist_full` and `o_trig_addr` cleared to 0.
- `i_arm` in ARMED or POST is ignored. Triggers outside ARMED are ignored.
- The edge register tracks `i_fault` in every state. A fault already high when arming does not trigger until it falls and rises again.
- Arithmetic: all pointers wrap modulo RAM_DEPTH by natural overflow. `i_post_cnt` ≤ RAM_DEPTH−1 by width, so post data never overwrites the trigger sample.

## Timing
- A tick in cycle N (in ARMED or POST) gives `o_ram_we` = 1 in cycle N+1 only, with `o_w_ram_addr` = the pre-increment `wr_ptr`. RAM data must be valid at N+1.
- `o_w_ram_addr` holds the last written address between strobes. It reads 0 after reset and after arm, until the first write.
- A trigger in cycle N updates `o_state`, `o_trig_addr` and `o_hist_full` in N+1.
- The final POST tick in cycle N gives `o_ram_we` in N+1 and `o_state` = DONE / `o_done` = 1 in N+1.
- A trigger with post count 0 gives DONE in N+1. A same-cycle tick is still written, and that sample is the trigger sample.
- `i_arm` in cycle N gives ARMED in N+1. A tick in N, while in IDLE or DONE, is not written.
- Reset mid-capture aborts immediately: state IDLE, `o_ram_we` low in the same cycle (asynchronous).

## Configuration
- `POSTMORTEM_SW_TRIG_EN` defined: trigger = fault rising edge OR `i_sw_trig`. Both in one cycle count as a single trigger.
- Not defined: `i_sw_trig` is unconnected internally and has no effect. The trigger is the fault edge only.

## Test plan
- Reset/idle (RAM_DEPTH=16): ticks without arm → `o_ram_we` never asserted; all outputs 0; state 0.
- Full history: arm, 20 ticks, fault edge, `i_post_cnt`=4, 4 ticks.
  - → writes at addresses 0..15, 0..3, then 4..7.
  - `o_trig_addr`=3; `o_hist_full`=1; DONE after the 24th write.
  - Further ticks produce no writes.
- Partial history: arm, 5 ticks, fault edge, `i_post_cnt`=2, 2 ticks → `o_trig_addr`=4, `o_hist_full`=0, last write at address 6, DONE.
- Simultaneous tick and fault edge after 7 ticks, `i_post_cnt`=0 → write at address 7; `o_trig_addr`=7; DONE next cycle.
- Fault held high across arm → no trigger; fault low then high → trigger. `i_arm` during POST is ignored. Reset asserted mid-POST → IDLE and `o_ram_we`=0 immediately.
- With `POSTMORTEM_SW_TRIG_EN`: `i_sw_trig` after 3 ticks → POST with `o_trig_addr`=2. Without the macro: the same stimulus stays in ARMED.
